// File: rtl/sequence_player.sv
// rtl/sequence_player.sv - Simon colour-sequence playback FSM driving one-hot LEDs
module sequence_player #(
    parameter int TICKS_PER_UNIT = 1,
    parameter int ON_UNITS       = 4,
    parameter int OFF_UNITS      = 2,
    parameter int DEPTH          = 10
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] level,
    output logic [3:0] rd_addr,
    input  logic [1:0] rd_data,
    output logic [3:0] led,
    output logic       busy,
    output logic       done
);

    localparam int N_ON  = ON_UNITS * TICKS_PER_UNIT;
    localparam int N_OFF = OFF_UNITS * TICKS_PER_UNIT;
    localparam int N_MAX = (N_ON > N_OFF) ? N_ON : N_OFF;
    localparam int CNT_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(N_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(N_OFF - 1);
    localparam logic [4:0]       DEPTH_V  = 5'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ON,
        S_OFF,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_index;
    logic [3:0]         r_level;
    logic [1:0]         r_code;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_level_ok;
    logic               w_cnt_zero;
    logic               w_last;

    // An out-of-range level skips playback and reports completion immediately
    assign w_level_ok = (level != 4'd0) && ({1'b0, level} <= DEPTH_V);
    assign w_cnt_zero = (r_cnt == '0);
    assign w_last     = (r_index == (r_level - 4'd1));

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start is only looked at in IDLE so busy/DONE ignore it
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_level_ok ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: w_next = S_ON;
            S_ON: begin
                if (w_cnt_zero) begin
                    w_next = S_OFF;
                end
            end
            S_OFF: begin
                if (w_cnt_zero) begin
                    w_next = w_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: level latch, entry index, colour code and phase counter loaded on state entry
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_index <= 4'd0;
            r_level <= 4'd0;
            r_code  <= 2'd0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start && w_level_ok) begin
                        r_level <= level;
                        r_index <= 4'd0;
                    end
                end
                S_FETCH: begin
                    r_code <= rd_data;
                    r_cnt  <= ON_LOAD;
                end
                S_ON: begin
                    if (w_cnt_zero) begin
                        r_cnt <= OFF_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_OFF: begin
                    if (w_cnt_zero) begin
                        if (!w_last) begin
                            r_index <= r_index + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded purely from registered state and the code register
    always_comb begin
        led     = 4'd0;
        busy    = 1'b0;
        done    = 1'b0;
        rd_addr = 4'd0;
        unique case (r_state)
            S_FETCH: begin
                busy    = 1'b1;
                rd_addr = r_index;
            end
            S_ON: begin
                busy = 1'b1;
                led  = 4'b0001 << r_code;
            end
            S_OFF:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
            end
        endcase
    end

endmodule
